// File: rtl/vga_pkg.sv
// Shared VGA constants: active-area defaults, RGB332 colours, sprite palette
// and the per-axis bounce step used by the sprite motion logic.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam logic [7:0] COLOR_BLACK = 8'h00;
  localparam logic [7:0] COLOR_WHITE = 8'hFF;
  localparam logic [7:0] COLOR_BG    = 8'h02;

  typedef struct packed {
    logic active;
    logic border;
    logic in_box;
  } pix_flags_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       neg;
    logic       bounce;
  } axis_t;

  function automatic logic [7:0] palette(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'hE0;
      3'd1:    c = 8'h1C;
      3'd2:    c = 8'h03;
      3'd3:    c = 8'hFC;
      3'd4:    c = 8'hE3;
      3'd5:    c = 8'h1F;
      3'd6:    c = 8'h92;
      default: c = 8'h6D;
    endcase
    return c;
  endfunction

  // One frame of motion on one axis; 11-bit sums keep the edge test from wrapping.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic neg,
                                      input logic [10:0] limit, input logic [10:0] size,
                                      input logic [10:0] speed);
    axis_t      r;
    logic [10:0] p;
    p        = {1'b0, pos};
    r.pos    = pos;
    r.neg    = neg;
    r.bounce = 1'b0;
    if (!neg) begin
      if (p + size + speed > limit) begin
        r.pos    = 10'(limit - size);
        r.neg    = 1'b1;
        r.bounce = 1'b1;
      end else begin
        r.pos = 10'(p + speed);
      end
    end else begin
      if (p < speed) begin
        r.pos    = '0;
        r.neg    = 1'b0;
        r.bounce = 1'b1;
      end else begin
        r.pos = 10'(p - speed);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_motion.sv
// Bouncing sprite position, direction and colour index, advanced once per frame
// when the beam reaches the first pixel of the first blanking line.
module sprite_motion
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned SIZE     = 32,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned X0       = 100,
  parameter int unsigned Y0       = 50
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [2:0] color_idx
);

  localparam logic [10:0] H_W     = 11'(H_ACTIVE);
  localparam logic [10:0] V_W     = 11'(V_ACTIVE);
  localparam logic [10:0] SIZE_W  = 11'(SIZE);
  localparam logic [10:0] SPEED_W = 11'(SPEED);

  logic [9:0] x_q, y_q;
  logic       left_q, up_q;
  logic [2:0] color_q;
  logic       frame_tick;
  axis_t      ax, ay;

  assign frame_tick = (h_count == 10'd0) && (v_count == 10'(V_ACTIVE));

  always_comb begin
    ax = axis_step(x_q, left_q, H_W, SIZE_W, SPEED_W);
    ay = axis_step(y_q, up_q, V_W, SIZE_W, SPEED_W);
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      x_q     <= 10'(X0);
      y_q     <= 10'(Y0);
      left_q  <= 1'b0;
      up_q    <= 1'b0;
      color_q <= 3'd0;
    end else if (frame_tick) begin
      x_q    <= ax.pos;
      y_q    <= ay.pos;
      left_q <= ax.neg;
      up_q   <= ay.neg;
      // A corner hit counts as a single bounce.
      if (ax.bounce || ay.bounce) color_q <= color_q + 3'd1;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign color_idx = color_q;

endmodule

// File: rtl/sprite_draw.sv
// Sprite overlay on a bordered background: two-stage pixel pipeline with the
// syncs delayed to stay aligned with rgb.
module sprite_draw
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned SIZE     = 32,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned X0       = 100,
  parameter int unsigned Y0       = 50
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic       hs_out,
  output logic       vs_out,
  output logic [7:0] rgb
);

  localparam logic [10:0] H_W    = 11'(H_ACTIVE);
  localparam logic [10:0] V_W    = 11'(V_ACTIVE);
  localparam logic [10:0] SIZE_W = 11'(SIZE);

  logic [9:0]  spr_x, spr_y;
  logic [2:0]  color_idx;
  logic [10:0] h_ext, v_ext, x_ext, y_ext;
  pix_flags_t  flags_d, flags_q;
  logic [7:0]  rgb_d, rgb_q;
  logic        hs_d1_q, hs_q, vs_d1_q, vs_q;

  sprite_motion #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .SIZE     (SIZE),
    .SPEED    (SPEED),
    .X0       (X0),
    .Y0       (Y0)
  ) u_motion (
    .clk_25    (clk_25),
    .rst       (rst),
    .h_count   (h_count),
    .v_count   (v_count),
    .x         (spr_x),
    .y         (spr_y),
    .color_idx (color_idx)
  );

  assign h_ext = {1'b0, h_count};
  assign v_ext = {1'b0, v_count};
  assign x_ext = {1'b0, spr_x};
  assign y_ext = {1'b0, spr_y};

  always_comb begin
    flags_d.active = (h_ext < H_W) && (v_ext < V_W);
    flags_d.border = flags_d.active &&
                     ((h_count == 10'd0) || (h_ext == H_W - 11'd1) ||
                      (v_count == 10'd0) || (v_ext == V_W - 11'd1));
    flags_d.in_box = (h_ext >= x_ext) && (h_ext < x_ext + SIZE_W) &&
                     (v_ext >= y_ext) && (v_ext < y_ext + SIZE_W);
  end

  // Border wins over the sprite; blanking always forces black.
  always_comb begin
    rgb_d = COLOR_BG;
    if (!flags_q.active)     rgb_d = COLOR_BLACK;
    else if (flags_q.border) rgb_d = COLOR_WHITE;
    else if (flags_q.in_box) rgb_d = palette(color_idx);
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      flags_q <= '0;
      rgb_q   <= COLOR_BLACK;
      hs_d1_q <= 1'b1;
      hs_q    <= 1'b1;
      vs_d1_q <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      flags_q <= flags_d;
      rgb_q   <= rgb_d;
      hs_d1_q <= hs_in;
      hs_q    <= hs_d1_q;
      vs_d1_q <= vs_in;
      vs_q    <= vs_d1_q;
    end
  end

  assign rgb    = rgb_q;
  assign hs_out = hs_q;
  assign vs_out = vs_q;

endmodule

// File: tb/tb_sprite_draw.sv
// Randomised bench for sprite_draw: two instances (default start and a
// corner-bound start) compared every cycle against a behavioural model.
module tb_sprite_draw;

  logic       clk_25 = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_count = '0;
  logic [9:0] v_count = '0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic       hs_out, vs_out, hs_c, vs_c;
  logic [7:0] rgb, rgb_c;

  sprite_draw dut (
    .clk_25  (clk_25),
    .rst     (rst),
    .h_count (h_count),
    .v_count (v_count),
    .hs_in   (hs_in),
    .vs_in   (vs_in),
    .hs_out  (hs_out),
    .vs_out  (vs_out),
    .rgb     (rgb)
  );

  sprite_draw #(
    .X0 (540),
    .Y0 (380)
  ) u_corner (
    .clk_25  (clk_25),
    .rst     (rst),
    .h_count (h_count),
    .v_count (v_count),
    .hs_in   (hs_in),
    .vs_in   (vs_in),
    .hs_out  (hs_c),
    .vs_out  (vs_c),
    .rgb     (rgb_c)
  );

  always #20 clk_25 = ~clk_25;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state, one slot per instance.
  int mx[2], my[2], mc[2], d1[2], rexp[2];
  bit ml[2], mu[2];
  bit hs1 = 1, hs2 = 1, vs1 = 1, vs2 = 1;
  int tick_n = 0;
  int X0S[2] = '{100, 540};
  int Y0S[2] = '{50, 380};

  function automatic int pal(input int i);
    int p[8] = '{'hE0, 'h1C, 'h03, 'hFC, 'hE3, 'h1F, 'h92, 'h6D};
    return p[i % 8];
  endfunction

  function automatic int pixel(input int h, input int v, input int x, input int y, input int c);
    if (h >= 640 || v >= 480) return 0;
    if (h == 0 || h == 639 || v == 0 || v == 479) return 'hFF;
    if (h >= x && h < x + 32 && v >= y && v < y + 32) return pal(c);
    return 'h02;
  endfunction

  task automatic move(input int p_in, input bit n_in, input int lim,
                      output int p, output bit n, output bit b);
    p = p_in; n = n_in; b = 0;
    if (!n_in) begin
      if (p_in + 32 + 2 > lim) begin p = lim - 32; n = 1; b = 1; end
      else p = p_in + 2;
    end else begin
      if (p_in < 2) begin p = 0; n = 0; b = 1; end
      else p = p_in - 2;
    end
  endtask

  task automatic step(input int h, input int v, input bit hs, input bit vs, input bit r);
    int xo, yo, np;
    bit nn, bx, by;
    h_count = 10'(h);
    v_count = 10'(v);
    hs_in   = hs;
    vs_in   = vs;
    rst     = r;
    @(posedge clk_25);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mx[i] = X0S[i]; my[i] = Y0S[i]; ml[i] = 0; mu[i] = 0; mc[i] = 0;
        d1[i] = 0; rexp[i] = 0;
      end else begin
        rexp[i] = d1[i];
        xo = mx[i];
        yo = my[i];
        if (h == 0 && v == 480) begin
          move(mx[i], ml[i], 640, np, nn, bx); mx[i] = np; ml[i] = nn;
          move(my[i], mu[i], 480, np, nn, by); my[i] = np; mu[i] = nn;
          if (bx || by) mc[i] = (mc[i] + 1) % 8;
        end
        // Position sampled with the pixel, colour as it stands one cycle later.
        d1[i] = pixel(h, v, xo, yo, mc[i]);
      end
    end
    if (!r && h == 0 && v == 480) tick_n++;
    if (r) begin
      hs1 = 1; hs2 = 1; vs1 = 1; vs2 = 1;
    end else begin
      hs2 = hs1; hs1 = hs; vs2 = vs1; vs1 = vs;
    end
    #1;
    check("rgb", rgb, rexp[0]);
    check("rgb_c", rgb_c, rexp[1]);
    check("hs_out", hs_out, hs2);
    check("vs_out", vs_out, vs2);
    check("hs_c", hs_c, hs2);
    check("vs_c", vs_c, vs2);
  endtask

  task automatic tick();
    step(0, 480, 1, 1, 0);
    step(1, 480, 1, 1, 0);
  endtask

  initial begin
    int h, v;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1);
    check("reset_rgb", rgb, 0);
    check("reset_hs", hs_out, 1);
    check("reset_x", dut.u_motion.x_q, 100);
    check("reset_y", dut.u_motion.y_q, 50);

    // Sprite at its start corner, background beside it, border and blanking.
    step(100, 50, 0, 1, 0);
    check("hs_hold", hs_out, 1);
    step(99, 50, 1, 1, 0);
    check("sprite_px", rgb, 'hE0);
    check("hs_delay2", hs_out, 0);
    step(0, 200, 1, 1, 0);
    check("bg_px", rgb, 'h02);
    check("hs_back", hs_out, 1);
    step(640, 200, 1, 1, 0);
    check("border_px", rgb, 'hFF);
    step(5, 5, 1, 1, 0);
    check("blank_px", rgb, 'h00);

    // h_count==0 off the tick line must not move; one full tick line moves once.
    for (int i = 0; i < 5; i++) step(0, 200, 1, 1, 0);
    check("no_move", dut.u_motion.x_q, 100);
    for (int i = 0; i < 800; i++) step(i, 480, (i < 700), 1, 0);
    check("line_x", dut.u_motion.x_q, 102);
    check("line_y", dut.u_motion.y_q, 52);

    while (tick_n < 255) begin
      tick();
      if (tick_n == 33) begin
        check("c33_x", u_corner.u_motion.x_q, 606);
        check("c33_y", u_corner.u_motion.y_q, 446);
      end
      if (tick_n == 34) begin
        check("c34_x", u_corner.u_motion.x_q, 608);
        check("c34_y", u_corner.u_motion.y_q, 448);
        check("c34_l", u_corner.u_motion.left_q, 0);
        check("c34_col", u_corner.u_motion.color_q, 0);
      end
      if (tick_n == 35) begin
        check("c35_x", u_corner.u_motion.x_q, 608);
        check("c35_y", u_corner.u_motion.y_q, 448);
        check("c35_l", u_corner.u_motion.left_q, 1);
        check("c35_u", u_corner.u_motion.up_q, 1);
        check("c35_col", u_corner.u_motion.color_q, 1);
      end
      if (tick_n == 253) begin
        check("m253_x", dut.u_motion.x_q, 606);
        check("m253_l", dut.u_motion.left_q, 0);
      end
      if (tick_n == 254) begin
        check("m254_x", dut.u_motion.x_q, 608);
        check("m254_l", dut.u_motion.left_q, 0);
        check("m254_col", dut.u_motion.color_q, 1);
      end
      if (tick_n == 255) begin
        check("m255_x", dut.u_motion.x_q, 608);
        check("m255_l", dut.u_motion.left_q, 1);
        check("m255_col", dut.u_motion.color_q, 2);
      end
    end

    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        h = 0; v = 480;
      end else if (r < 60) begin
        int k;
        k = (i % 2 == 0) ? 0 : 1;
        h = mx[k] + $urandom_range(0, 40) - 4;
        v = my[k] + $urandom_range(0, 40) - 4;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      step(h, v, 1'($urandom), 1'($urandom), 0);
    end

    // Mid-frame reset with syncs low going in.
    step(300, 250, 0, 0, 0);
    step(301, 250, 0, 0, 0);
    step(302, 250, 0, 0, 1);
    check("mrst_x", dut.u_motion.x_q, 100);
    check("mrst_y", dut.u_motion.y_q, 50);
    check("mrst_rgb", rgb, 0);
    check("mrst_hs", hs_out, 1);
    check("mrst_vs", vs_out, 1);
    step(110, 60, 1, 1, 0);
    step(10, 10, 1, 1, 0);
    check("post_rgb", rgb, 'hE0);
    tick();
    check("post_x", dut.u_motion.x_q, 102);
    check("post_y", dut.u_motion.y_q, 52);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
